// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Optional hit/mispredict statistics counters are enabled with `define BTB_STATS_EN.
module branch_target_buffer #(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_pc,
  output logic        predicted_taken,
  output logic [31:0] predicted_target,
  output logic [31:0] next_pc,
  input  logic        update_en,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_taken,
  input  logic        ex_predicted_taken,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [31:0]       target_q [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];

  // Lookup side
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  assign f_idx = fetch_pc[IDX_W+1:2];
  assign f_tag = fetch_pc[31:IDX_W+2];
  // Gated by rst so the fetch stage never sees a prediction from stale state.
  assign f_hit = !rst && valid_q[f_idx] && (tag_q[f_idx] == f_tag);

  assign predicted_taken  = f_hit && ctr_q[f_idx][1];
  assign predicted_target = f_hit ? target_q[f_idx] : 32'd0;
  assign next_pc          = predicted_taken ? predicted_target : (fetch_pc + 32'd4);

  // Update side
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic [1:0]       u_ctr;
  logic [1:0]       u_ctr_next;

  assign u_idx = ex_pc[IDX_W+1:2];
  assign u_tag = ex_pc[31:IDX_W+2];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign u_ctr = ctr_q[u_idx];

  always_comb begin
    u_ctr_next = u_ctr;
    if (ex_taken) begin
      if (u_ctr != 2'b11) u_ctr_next = u_ctr + 2'b01;
    end else begin
      if (u_ctr != 2'b00) u_ctr_next = u_ctr - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'd0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (update_en) begin
      if (u_hit) begin
        ctr_q[u_idx] <= u_ctr_next;
        if (ex_taken) target_q[u_idx] <= ex_target;
      end else if (ex_taken) begin
        // Allocation evicts whatever aliased entry occupied this index.
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= ex_target;
        ctr_q[u_idx]    <= 2'b10;
      end
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] lookups_q;
  logic [31:0] mispredicts_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lookups_q     <= 32'd0;
      mispredicts_q <= 32'd0;
    end else begin
      if (f_hit && (lookups_q != 32'hFFFF_FFFF))
        lookups_q <= lookups_q + 32'd1;
      if (update_en && (ex_taken != ex_predicted_taken) && (mispredicts_q != 32'hFFFF_FFFF))
        mispredicts_q <= mispredicts_q + 32'd1;
    end
  end

  assign stat_lookups     = lookups_q;
  assign stat_mispredicts = mispredicts_q;

  logic unused_bits;
  assign unused_bits = ^{fetch_pc[1:0], ex_pc[1:0]};
`else
  assign stat_lookups     = 32'd0;
  assign stat_mispredicts = 32'd0;

  logic unused_bits;
  assign unused_bits = ^{fetch_pc[1:0], ex_pc[1:0], ex_predicted_taken};
`endif

endmodule
